// File: rtl/tt_sweep_ctrl.sv
// Exhaustive 3-input sweep controller: drives A/B/C through 000..111, lets each vector settle,
// then checks X/Y from the logic block under test. Optional first-fail capture: TT_SWEEP_FIRSTFAIL_EN.
module tt_sweep_ctrl #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_x,
    input  logic       dut_y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [7:0] fail_vec,
    output logic [2:0] first_fail_idx,
    output logic       first_fail_vld
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] err_q, err_d;
    logic [7:0] fail_q, fail_d;
    logic       exp_x, exp_y, mismatch;

`ifdef TT_SWEEP_FIRSTFAIL_EN
    logic [2:0] ff_idx_q, ff_idx_d;
    logic       ff_vld_q, ff_vld_d;
`endif

    // Reference truth of the block under test for the vector currently applied
    assign exp_x    = idx_q[2] ^ idx_q[1];
    assign exp_y    = (~idx_q[2] & idx_q[0]) | (idx_q[1] & idx_q[0]);
    assign mismatch = (dut_x != exp_x) || (dut_y != exp_y);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fail_d  = fail_q;
`ifdef TT_SWEEP_FIRSTFAIL_EN
        ff_idx_d = ff_idx_q;
        ff_vld_d = ff_vld_q;
`endif
        busy = 1'b0;
        done = 1'b0;
        pass = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE) begin
                    done = 1'b1;
                    pass = (err_q == 4'd0);
                end
                if (start) begin
                    state_d = S_SETTLE;
                    idx_d   = 3'd0;
                    cnt_d   = CNT_LOAD;
                    err_d   = 4'd0;
                    fail_d  = 8'd0;
`ifdef TT_SWEEP_FIRSTFAIL_EN
                    ff_idx_d = 3'd0;
                    ff_vld_d = 1'b0;
`endif
                end
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_SAMPLE: begin
                busy = 1'b1;
                if (mismatch) begin
                    fail_d[idx_q] = 1'b1;
                    err_d         = err_q + 4'd1;
`ifdef TT_SWEEP_FIRSTFAIL_EN
                    if (!ff_vld_q) begin
                        ff_idx_d = idx_q;
                        ff_vld_d = 1'b1;
                    end
`endif
                end
                // The next vector is launched on the same edge that samples this one
                if (idx_q == 3'd7) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SETTLE;
                    idx_d   = idx_q + 3'd1;
                    cnt_d   = CNT_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 4'd0;
            err_q   <= 4'd0;
            fail_q  <= 8'd0;
`ifdef TT_SWEEP_FIRSTFAIL_EN
            ff_idx_q <= 3'd0;
            ff_vld_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
`ifdef TT_SWEEP_FIRSTFAIL_EN
            ff_idx_q <= ff_idx_d;
            ff_vld_q <= ff_vld_d;
`endif
        end
    end

    assign {a, b, c} = idx_q;
    assign err_cnt   = err_q;
    assign fail_vec  = fail_q;

`ifdef TT_SWEEP_FIRSTFAIL_EN
    assign first_fail_idx = ff_idx_q;
    assign first_fail_vld = ff_vld_q;
`else
    assign first_fail_idx = 3'd0;
    assign first_fail_vld = 1'b0;
`endif

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Scoreboard bench for tt_sweep_ctrl: two instances (SETTLE=2 and SETTLE=1) driven by a
// behavioural model of the logic block with injectable faults.
module tb_tt_sweep_ctrl;

    localparam int S0 = 2;
    localparam int S1 = 1;

    typedef struct {
        logic [7:0] fv;
        logic [3:0] err;
        logic       pass;
        logic [2:0] ffi;
        logic       ffv;
    } exp_t;

    logic clk = 1'b0;
    logic rst, start0, start1;
    logic a0, b0, c0, busy0, done0, pass0, ffv0, x0, y0;
    logic a1, b1, c1, busy1, done1, pass1, ffv1, x1, y1;
    logic [3:0] err0, err1;
    logic [7:0] fv0, fv1;
    logic [2:0] ffi0, ffi1;

    int         mode0, mode1;
    logic [7:0] xm0, ym0, xm1, ym1;
    exp_t       q0[$];
    exp_t       q1[$];
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    // Logic block model: 0 good, 1 X stuck-at-0, 2 Y stuck-at-1, 3 per-vector flips from masks
    function automatic logic [1:0] block_out(int mode, logic [7:0] xm, logic [7:0] ym, logic [2:0] v);
        logic gx, gy;
        gx = v[2] ^ v[1];
        gy = (~v[2] & v[0]) | (v[1] & v[0]);
        case (mode)
            1:       return {1'b0, gy};
            2:       return {gx, 1'b1};
            3:       return {gx ^ xm[v], gy ^ ym[v]};
            default: return {gx, gy};
        endcase
    endfunction

    assign {x0, y0} = block_out(mode0, xm0, ym0, {a0, b0, c0});
    assign {x1, y1} = block_out(mode1, xm1, ym1, {a1, b1, c1});

    tt_sweep_ctrl #(.SETTLE(S0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .dut_x(x0), .dut_y(y0),
        .a(a0), .b(b0), .c(c0), .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err0), .fail_vec(fv0), .first_fail_idx(ffi0), .first_fail_vld(ffv0)
    );

    tt_sweep_ctrl #(.SETTLE(S1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .dut_x(x1), .dut_y(y1),
        .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .fail_vec(fv1), .first_fail_idx(ffi1), .first_fail_vld(ffv1)
    );

    function automatic exp_t make_exp(logic [7:0] fv);
        exp_t e;
        e.fv   = fv;
        e.err  = 4'($countones(fv));
        e.pass = (fv == 8'd0);
        e.ffi  = 3'd0;
        e.ffv  = 1'b0;
`ifdef TT_SWEEP_FIRSTFAIL_EN
        e.ffv = (fv != 8'd0);
        for (int i = 7; i >= 0; i--) begin
            if (fv[i]) e.ffi = 3'(i);
        end
`endif
        return e;
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic checkIdle(int inst);
        logic [21:0] v;
        if (inst == 0) v = {a0, b0, c0, busy0, done0, pass0, err0, fv0, ffi0, ffv0};
        else           v = {a1, b1, c1, busy1, done1, pass1, err1, fv1, ffi1, ffv1};
        checkOutput($sformatf("idle outputs dut%0d", inst), 32'(v), 32'd0);
    endtask

    task automatic resetAll();
        @(posedge clk); #1;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Configure the modelled block, queue the expected result, then pulse start
    task automatic applyStimulus(int inst, int mode, logic [7:0] xm, logic [7:0] ym, logic [7:0] exp_fv);
        @(posedge clk); #1;
        if (inst == 0) begin
            mode0 = mode; xm0 = xm; ym0 = ym;
            q0.push_back(make_exp(exp_fv));
            start0 = 1'b1;
        end else begin
            mode1 = mode; xm1 = xm; ym1 = ym;
            q1.push_back(make_exp(exp_fv));
            start1 = 1'b1;
        end
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic waitDone(int inst);
        bit got = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ((inst == 0) ? done0 : done1) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            tests++;
            fails++;
            $display("[TB] FAIL done timeout dut%0d: got done=0, expected done=1", inst);
            resetAll();
        end
    endtask

    // Per-instance monitor: checks the vector sequence while busy and pops the scoreboard on done
    task automatic monitor(int inst);
        int         bc = 0;
        logic       pd = 1'b0;
        int         settle;
        exp_t       e;
        logic [2:0] abc;
        logic       bz, dn, ps, fvd;
        logic [3:0] er;
        logic [7:0] fv;
        logic [2:0] fi;
        settle = (inst == 0) ? S0 : S1;
        forever begin
            @(negedge clk);
            if (inst == 0) begin
                abc = {a0, b0, c0}; bz = busy0; dn = done0; ps = pass0;
                er = err0; fv = fv0; fi = ffi0; fvd = ffv0;
            end else begin
                abc = {a1, b1, c1}; bz = busy1; dn = done1; ps = pass1;
                er = err1; fv = fv1; fi = ffi1; fvd = ffv1;
            end
            if (rst) begin
                bc = 0;
                pd = 1'b0;
            end else begin
                if (bz) begin
                    bc++;
                    checkOutput($sformatf("abc sequence dut%0d", inst), 32'(abc), 32'((bc - 1) / (settle + 1)));
                end
                if (dn && !pd) begin
                    checkOutput($sformatf("busy cycles dut%0d", inst), 32'(bc), 32'(8 * (settle + 1)));
                    bc = 0;
                    if ((inst == 0 ? q0.size() : q1.size()) == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL unexpected done dut%0d: got done=1, expected no pending sweep", inst);
                    end else begin
                        e = (inst == 0) ? q0.pop_front() : q1.pop_front();
                        checkOutput($sformatf("fail_vec dut%0d", inst), 32'(fv), 32'(e.fv));
                        checkOutput($sformatf("err_cnt dut%0d", inst), 32'(er), 32'(e.err));
                        checkOutput($sformatf("pass dut%0d", inst), 32'(ps), 32'(e.pass));
                        checkOutput($sformatf("first_fail_idx dut%0d", inst), 32'(fi), 32'(e.ffi));
                        checkOutput($sformatf("first_fail_vld dut%0d", inst), 32'(fvd), 32'(e.ffv));
                    end
                end
                if (dn) checkOutput($sformatf("abc in done dut%0d", inst), 32'(abc), 32'd7);
                pd = dn;
            end
        end
    endtask

    initial begin
        logic [7:0] xm, ym;
        bit         seen;
        rst    = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        mode0  = 0; mode1 = 0;
        xm0 = 8'd0; ym0 = 8'd0; xm1 = 8'd0; ym1 = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkIdle(0);
        checkIdle(1);

        fork
            monitor(0);
            monitor(1);
        join_none

        // Clean sweep, then the two stuck-at faults
        applyStimulus(0, 0, 8'd0, 8'd0, 8'h00);
        waitDone(0);
        applyStimulus(0, 1, 8'd0, 8'd0, 8'b0011_1100);
        waitDone(0);

        // Restart from DONE must clear the previous failing results immediately
        applyStimulus(0, 2, 8'd0, 8'd0, 8'b0111_0101);
        @(negedge clk);
        checkOutput("cleared err_cnt on restart", 32'(err0), 32'd0);
        checkOutput("cleared fail_vec on restart", 32'(fv0), 32'd0);
        checkOutput("busy/done after restart", 32'({busy0, done0}), 32'b10);
        waitDone(0);

        // start while busy is ignored
        applyStimulus(0, 3, 8'h81, 8'h00, 8'h81);
        repeat (9) @(posedge clk);
        #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        waitDone(0);

        // Reset while vector 4 is applied
        applyStimulus(0, 1, 8'd0, 8'd0, 8'b0011_1100);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ({a0, b0, c0} == 3'd4) begin
                seen = 1;
                break;
            end
        end
        checkOutput("reached idx 4 before reset", 32'(seen), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        q0.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkIdle(0);
        mode0 = 0;
        applyStimulus(0, 0, 8'd0, 8'd0, 8'h00);
        waitDone(0);

        for (int i = 0; i < 6; i++) begin
            xm = 8'($urandom);
            ym = (i == 2) ? 8'd0 : 8'($urandom);
            if (i == 0) xm = 8'd0;
            applyStimulus(0, 3, xm, ym, xm | ym);
            waitDone(0);
        end

        // SETTLE=1 instance
        applyStimulus(1, 0, 8'd0, 8'd0, 8'h00);
        waitDone(1);
        applyStimulus(1, 2, 8'd0, 8'd0, 8'b0111_0101);
        waitDone(1);
        for (int i = 0; i < 3; i++) begin
            xm = 8'($urandom);
            ym = 8'($urandom);
            applyStimulus(1, 3, xm, ym, xm | ym);
            waitDone(1);
        end

        @(negedge clk);
        checkOutput("scoreboard drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tt_sweep_ctrl.md
TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE, default 2, meaning cycles each input vector is held before sampling; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, sweep request, sampled in IDLE or DONE only.
REQ-005 The block SHALL have ports dut_x and dut_y, input, 1 each, the X/Y outputs of the logic block under test.
REQ-006 The block SHALL have ports a, b and c, output, 1 each, registered stimulus driven to the logic block's A, B, C.
REQ-007 The block SHALL have port busy, output, 1, high in SETTLE and SAMPLE.
REQ-008 The block SHALL have port done, output, 1, high while in DONE.
REQ-009 The block SHALL have port pass, output, 1, high in DONE when err_cnt==0, else 0.
REQ-010 The block SHALL have port err_cnt, output, 4, number of failing vectors (0..8).
REQ-011 The block SHALL have port fail_vec, output, 8; bit i is set when vector i failed.
REQ-012 The block SHALL have ports first_fail_idx, output, 3, and first_fail_vld, output, 1 (see Configuration).

Function
REQ-013 Vector index idx[2:0] SHALL map to {a,b,c} = idx, with a as MSB.
REQ-014 Expected results SHALL be exp_x = a XOR b and exp_y = (~a & c) | (b & c).
REQ-015 FSM states SHALL be IDLE, SETTLE, SAMPLE and DONE.
REQ-016 In IDLE or DONE with start=1, the next state SHALL be SETTLE, with idx=0, {a,b,c}=000, settle counter=SETTLE-1, and err_cnt, fail_vec and first-fail cleared.
REQ-017 SETTLE SHALL decrement the counter each cycle and move to SAMPLE on the cycle the counter is 0.
REQ-018 SAMPLE SHALL compare dut_x/dut_y against exp_x/exp_y for the current idx.
REQ-019 On mismatch in SAMPLE, the block SHALL set fail_vec[idx] and increment err_cnt.
REQ-020 In SAMPLE with idx<7, the block SHALL increment idx, update {a,b,c} and reload the counter in the same cycle, then return to SETTLE.
REQ-021 In SAMPLE with idx==7, the next state SHALL be DONE.
REQ-022 Each vector SHALL take exactly SETTLE+1 cycles; DONE SHALL be entered 8*(SETTLE+1) cycles after the start-accept edge.
REQ-023 DONE SHALL hold all results and {a,b,c}=111 until a new start or reset.
REQ-024 start while busy SHALL be ignored, with no restart and no result change.
REQ-025 IDLE SHALL drive {a,b,c}=000.
REQ-026 err_cnt SHALL never exceed 8; no wrap logic is required.

Reset
REQ-027 rst=1 at a clock edge SHALL force state IDLE, {a,b,c}=000, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0, first_fail_idx=0 and first_fail_vld=0.
REQ-028 rst SHALL take priority over start and over any in-progress sweep; reset mid-sweep SHALL discard partial results.

Configuration
REQ-029 With macro TT_SWEEP_FIRSTFAIL_EN defined, on the first mismatch of a sweep the block SHALL latch idx into first_fail_idx and set first_fail_vld; later mismatches SHALL not change them.
REQ-030 Without TT_SWEEP_FIRSTFAIL_EN, first_fail_idx and first_fail_vld SHALL be tied to 0, with ports still present and all other behaviour identical.

Verification
REQ-031 The bench SHALL cover: SETTLE=2, correct bench model of the logic block, start pulse -> busy for 24 cycles, then done=1, pass=1, err_cnt=0, fail_vec=8'h00.
REQ-032 The bench SHALL cover: dut_x stuck at 0 -> fail_vec=8'b00111100, err_cnt=4, pass=0, first_fail_idx=2 (with macro).
REQ-033 The bench SHALL cover: dut_y stuck at 1 -> fail_vec=8'b01110101, err_cnt=5, first_fail_idx=0, first_fail_vld=1 (with macro), and first_fail_idx=0, first_fail_vld=0 (without macro).
REQ-034 The bench SHALL cover: rst asserted at idx=4 mid-sweep -> next cycle state IDLE, all outputs 0; a new start then gives a full clean 24-cycle sweep.
REQ-035 The bench SHALL cover: start re-pulsed during busy -> ignored, done still at cycle 24; start in DONE -> results cleared, new sweep begins.
REQ-036 The bench SHALL cover: SETTLE=1 -> {a,b,c} changes every 2 cycles, 000 through 111 in order, done after 16 cycles.
